// File: rtl/core_pkg.sv
// Shared definitions for the memory stage: access-size encodings, FSM states
// and the legality rule for loads/stores.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    // An instruction flagged as both load and store is never legal.
    function automatic logic access_legal(input logic       is_load,
                                          input logic       is_store,
                                          input logic [2:0] f3,
                                          input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        if (is_load && is_store) begin
            ok = 1'b0;
        end else if (is_load) begin
            case (f3)
                F3_LB, F3_LBU: ok = 1'b1;
                F3_LH, F3_LHU: ok = ~a[0];
                F3_LW:         ok = (a == 2'b00);
                default:       ok = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_SB:   ok = 1'b1;
                F3_SH:   ok = ~a[0];
                F3_SW:   ok = (a == 2'b00);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module mem_load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    import core_pkg::*;

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        case (funct3)
            F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  data = {24'd0, shifted[7:0]};
            F3_LHU:  data = {16'd0, shifted[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/stage_memory.sv
// Memory pipeline stage: ALU passthrough, RV32I loads/stores over a
// valid/ready data port, registered results to writeback.
module stage_memory #(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 execute_valid,
    input  logic [RF_ADDR_W-1:0] execute_rd,
    input  logic [XLEN-1:0]      execute_alu_result,
    input  logic [XLEN-1:0]      execute_store_data,
    input  logic                 execute_wr_enable,
    input  logic                 execute_mem_to_reg,
    input  logic                 execute_mem_write,
    input  logic [2:0]           execute_funct3,
    output logic                 mem_stall,
    output logic                 dmem_req_valid,
    input  logic                 dmem_req_ready,
    output logic [XLEN-1:0]      dmem_req_addr,
    output logic                 dmem_req_we,
    output logic [XLEN-1:0]      dmem_req_wdata,
    output logic [3:0]           dmem_req_be,
    input  logic                 dmem_rsp_valid,
    input  logic [XLEN-1:0]      dmem_rsp_rdata,
    output logic                 memory_valid,
    output logic [RF_ADDR_W-1:0] memory_rd,
    output logic                 memory_wr_enable,
    output logic [XLEN-1:0]      memory_result,
    output logic                 memory_fault
);
    import core_pkg::*;

    mem_state_t           state_q, state_d;
    logic [XLEN-1:0]      addr_q, addr_d;
    logic [XLEN-1:0]      sdata_q, sdata_d;
    logic [2:0]           f3_q, f3_d;
    logic [RF_ADDR_W-1:0] rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic                 store_q, store_d;

    logic                 valid_q, valid_d;
    logic                 fault_q, fault_d;
    logic [RF_ADDR_W-1:0] out_rd_q, out_rd_d;
    logic                 out_wr_q, out_wr_d;
    logic [XLEN-1:0]      result_q, result_d;

    logic [XLEN-1:0]      load_data;
    logic                 in_req;

    mem_load_align u_align (
        .rdata  (dmem_rsp_rdata),
        .addr   (addr_q[1:0]),
        .funct3 (f3_q),
        .data   (load_data)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        sdata_d  = sdata_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        store_d  = store_q;
        valid_d  = 1'b0;
        fault_d  = 1'b0;
        out_rd_d = out_rd_q;
        out_wr_d = out_wr_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (execute_valid) begin
                    out_rd_d = execute_rd;
                    result_d = execute_alu_result;
                    if (!execute_mem_to_reg && !execute_mem_write) begin
                        valid_d  = 1'b1;
                        out_wr_d = execute_wr_enable;
                    end else if (access_legal(execute_mem_to_reg, execute_mem_write,
                                              execute_funct3, execute_alu_result[1:0])) begin
                        addr_d  = execute_alu_result;
                        sdata_d = execute_store_data;
                        f3_d    = execute_funct3;
                        rd_d    = execute_rd;
                        wr_d    = execute_wr_enable;
                        store_d = execute_mem_write;
                        state_d = REQ;
                    end else begin
                        valid_d  = 1'b1;
                        fault_d  = 1'b1;
                        out_wr_d = 1'b0;
                    end
                end
            end
            REQ: begin
                if (dmem_req_ready) begin
                    if (store_q) begin
                        valid_d  = 1'b1;
                        out_wr_d = 1'b0;
                        out_rd_d = rd_q;
                        result_d = addr_q;
                        state_d  = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_rsp_valid) begin
                    valid_d  = 1'b1;
                    out_wr_d = wr_q;
                    out_rd_d = rd_q;
                    result_d = load_data;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            sdata_q  <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            wr_q     <= 1'b0;
            store_q  <= 1'b0;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
            out_rd_q <= '0;
            out_wr_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            sdata_q  <= sdata_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            store_q  <= store_d;
            valid_q  <= valid_d;
            fault_q  <= fault_d;
            out_rd_q <= out_rd_d;
            out_wr_q <= out_wr_d;
            result_q <= result_d;
        end
    end

    // Request fields come only from latched state, so they hold under back-pressure.
    always_comb begin
        in_req         = (state_q == REQ);
        dmem_req_be    = 4'b0000;
        dmem_req_wdata = '0;
        if (in_req) begin
            if (store_q) begin
                case (f3_q)
                    F3_SB: begin
                        dmem_req_be    = 4'b0001 << addr_q[1:0];
                        dmem_req_wdata = {4{sdata_q[7:0]}};
                    end
                    F3_SH: begin
                        dmem_req_be    = 4'b0011 << {addr_q[1], 1'b0};
                        dmem_req_wdata = {2{sdata_q[15:0]}};
                    end
                    default: begin
                        dmem_req_be    = 4'b1111;
                        dmem_req_wdata = sdata_q;
                    end
                endcase
            end else begin
                dmem_req_be = 4'b1111;
            end
        end
    end

    assign mem_stall        = (state_q != IDLE);
    assign dmem_req_valid   = in_req;
    assign dmem_req_we      = in_req & store_q;
    assign dmem_req_addr    = {addr_q[XLEN-1:2], 2'b00};
    assign memory_valid     = valid_q;
    assign memory_fault     = fault_q;
    assign memory_rd        = out_rd_q;
    assign memory_wr_enable = out_wr_q;
    assign memory_result    = result_q;

endmodule
